sha256_padder: RTL

Upstream message-preparation stage for the SHA-256 core. It accepts an arbitrary-length byte stream over a valid/ready handshake, applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length) and emits complete 512-bit blocks. Each block is emitted as sixteen 32-bit big-endian words with first/last markers, ready to drive the core's `message0..message15` inputs and its load strobe. The markers also tell the core when to select the IV versus chaining values.

---
 rtl/sha256_padder_if.sv | 23 ++
 rtl/sha256_padder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sha256_padder_if.sv
// Byte-stream input and 512-bit block output of the SHA-256 message padder.
// master = producer/consumer side, slave = padder side.
interface sha256_padder_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] o_block;
  logic         o_valid;
  logic         i_ready;
  logic         o_first;
  logic         o_last;

  modport master (
    output in_data, in_valid, in_last, i_ready,
    input  in_ready, o_block, o_valid, o_first, o_last
  );

  modport slave (
    input  in_data, in_valid, in_last, i_ready,
    output in_ready, o_block, o_valid, o_first, o_last
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: bytes in, padded 512-bit blocks out with first/last markers.
// Optional SHA256_PADDER_EMPTY_MSG_EN adds in_empty to emit the padding of a zero-length message.
module sha256_padder #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef SHA256_PADDER_EMPTY_MSG_EN
  input  logic in_empty,
`endif
  sha256_padder_if.slave bus
);
  localparam int BLOCK_W = 16 * DATA_WIDTH;

  typedef enum logic [1:0] {S_ABSORB, S_PAD, S_EXTRA, S_EMIT} state_t;

  state_t               r_state;
  logic [BLOCK_W-1:0]   r_buf;
  logic [5:0]           r_idx;
  logic [6:0]           r_q;
  logic [LEN_WIDTH-1:0] r_nbytes;
  logic                 r_first_pending;
  logic                 r_need_extra;
  logic                 r_pad80;
  logic                 r_valid;
  logic                 r_first;
  logic                 r_last;

  logic [LEN_WIDTH-1:0] w_bits;
  logic [63:0]          w_len;

  // Bit length wraps modulo 2^LEN_WIDTH; upper length bits stay zero.
  assign w_bits = r_nbytes << 3;
  assign w_len  = 64'(w_bits);

  assign bus.in_ready = (r_state == S_ABSORB) && !rst;
  assign bus.o_block  = r_buf;
  assign bus.o_valid  = r_valid;
  assign bus.o_first  = r_first;
  assign bus.o_last   = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_ABSORB;
      r_buf           <= '0;
      r_idx           <= '0;
      r_q             <= '0;
      r_nbytes        <= '0;
      r_first_pending <= 1'b1;
      r_need_extra    <= 1'b0;
      r_pad80         <= 1'b0;
      r_valid         <= 1'b0;
      r_first         <= 1'b0;
      r_last          <= 1'b0;
    end else begin
      case (r_state)
        S_ABSORB: begin
          if (bus.in_valid) begin
            for (int j = 0; j < 64; j++)
              if (j[5:0] == r_idx) r_buf[BLOCK_W-1-8*j -: 8] <= bus.in_data;
            r_idx    <= r_idx + 6'd1;
            r_nbytes <= r_nbytes + LEN_WIDTH'(1);
            if (bus.in_last) begin
              r_q     <= {1'b0, r_idx} + 7'd1;
              r_state <= S_PAD;
            end else if (r_idx == 6'd63) begin
              r_valid <= 1'b1;
              r_first <= r_first_pending;
              r_last  <= 1'b0;
              r_state <= S_EMIT;
            end
          end
`ifdef SHA256_PADDER_EMPTY_MSG_EN
          else if (in_empty && r_idx == 6'd0) begin
            r_nbytes        <= '0;
            r_pad80         <= 1'b1;
            r_first_pending <= 1'b1;
            r_state         <= S_EXTRA;
          end
`endif
        end
        S_PAD: begin
          // Bytes past the data are already zero: the buffer is cleared on every handshake.
          for (int j = 0; j < 64; j++)
            if (j[6:0] == r_q) r_buf[BLOCK_W-1-8*j -: 8] <= 8'h80;
          r_valid <= 1'b1;
          r_first <= r_first_pending;
          r_state <= S_EMIT;
          if (r_q <= 7'd55) begin
            r_buf[63:0] <= w_len;
            r_last      <= 1'b1;
          end else begin
            r_last       <= 1'b0;
            r_need_extra <= 1'b1;
            r_pad80      <= r_q[6];
          end
        end
        S_EXTRA: begin
          if (r_pad80) r_buf[BLOCK_W-1 -: 8] <= 8'h80;
          r_buf[63:0] <= w_len;
          r_pad80     <= 1'b0;
          r_valid     <= 1'b1;
          r_first     <= r_first_pending;
          r_last      <= 1'b1;
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.i_ready) begin
            r_buf           <= '0;
            r_idx           <= '0;
            r_valid         <= 1'b0;
            r_first         <= 1'b0;
            r_last          <= 1'b0;
            r_first_pending <= r_last;
            if (r_need_extra) begin
              r_need_extra <= 1'b0;
              r_state      <= S_EXTRA;
            end else begin
              r_state <= S_ABSORB;
              if (r_last) r_nbytes <= '0;
            end
          end
        end
        default: r_state <= S_ABSORB;
      endcase
    end
  end
endmodule
